// File: rtl/cfu_mem_pkg.sv
// Shared types and constants for the CFU memory command sequencer.
package cfu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      RESP
   } seq_state_t;

   localparam logic [2:0] OP_READ   = 3'd0;
   localparam logic [2:0] OP_WRITE  = 3'd1;
   localparam logic [2:0] OP_SUM_N  = 3'd2;
   localparam logic [2:0] OP_STATUS = 3'd3;
   // Any nonzero funct7 is folded onto this unassigned funct3 code.
   localparam logic [2:0] OP_UNDEF  = 3'd7;

   localparam logic [31:0] RSP_BUS_ERR = 32'hFFFF_FFFF;
   localparam logic [31:0] RSP_TIMEOUT = 32'hDEAD_BEEF;

endpackage

// File: rtl/cfu_mem_timeout.sv
// Request watchdog for the command sequencer; built only when CFU_MEM_TIMEOUT_EN is defined.
`ifdef CFU_MEM_TIMEOUT_EN
module cfu_mem_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && !expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Fires during the TIMEOUT_CYCLES-th consecutive enabled cycle.
   assign expired = enable && (count_reg == TW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/cfu_mem_cmd_seq.sv
// CFU command sequencer driving single-word RAM controller requests (READ/WRITE/SUM_N/STATUS).
// Optional request watchdog enabled by defining CFU_MEM_TIMEOUT_EN.
module cfu_mem_cmd_seq
   import cfu_mem_pkg::*;
#(
   parameter int MAX_COUNT      = 256,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_function_id,
   input  logic [31:0] cmd_inputs_0,
   input  logic [31:0] cmd_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_outputs_0,
   output logic        req_read,
   output logic        req_write,
   output logic        req_burst,
   output logic [29:0] req_address,
   output logic [31:0] req_wdata,
   output logic [3:0]  req_byte_enable,
   input  logic        mem_ack,
   input  logic        mem_err,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(MAX_COUNT + 1);

   seq_state_t    state_reg, state_next;
   logic [2:0]    op_reg, op_next;
   logic [29:0]   addr_reg, addr_next;
   logic [31:0]   wdata_reg, wdata_next;
   logic [3:0]    be_reg, be_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [31:0]   acc_reg, acc_next;
   logic [31:0]   rsp_reg, rsp_next;
   logic          err_flag_reg, err_flag_next;
   logic          timeout_flag_reg, timeout_flag_next;

   logic [2:0]    op_dec;
   logic [15:0]   cnt_req;
   logic [CW-1:0] cnt_clamped;
   logic          timed_out;
   logic          unused_addr_lsb;

   assign op_dec      = (cmd_function_id[9:3] == 7'd0) ? cmd_function_id[2:0] : OP_UNDEF;
   assign cnt_req     = cmd_inputs_1[15:0];
   assign cnt_clamped = (cnt_req > 16'(MAX_COUNT)) ? CW'(MAX_COUNT) : CW'(cnt_req);
   assign unused_addr_lsb = ^cmd_inputs_0[1:0];

`ifdef CFU_MEM_TIMEOUT_EN
   cfu_mem_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_reg != REQ),
      .enable (state_reg == REQ),
      .expired(timed_out)
   );
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= IDLE;
         op_reg           <= OP_READ;
         addr_reg         <= '0;
         wdata_reg        <= '0;
         be_reg           <= '0;
         cnt_reg          <= '0;
         acc_reg          <= '0;
         rsp_reg          <= '0;
         err_flag_reg     <= 1'b0;
         timeout_flag_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         op_reg           <= op_next;
         addr_reg         <= addr_next;
         wdata_reg        <= wdata_next;
         be_reg           <= be_next;
         cnt_reg          <= cnt_next;
         acc_reg          <= acc_next;
         rsp_reg          <= rsp_next;
         err_flag_reg     <= err_flag_next;
         timeout_flag_reg <= timeout_flag_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      op_next           = op_reg;
      addr_next         = addr_reg;
      wdata_next        = wdata_reg;
      be_next           = be_reg;
      cnt_next          = cnt_reg;
      acc_next          = acc_reg;
      rsp_next          = rsp_reg;
      err_flag_next     = err_flag_reg;
      timeout_flag_next = timeout_flag_reg;

      unique case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               op_next    = op_dec;
               addr_next  = cmd_inputs_0[31:2];
               wdata_next = cmd_inputs_1;
               cnt_next   = cnt_clamped;
               acc_next   = '0;
               be_next    = 4'h0;
               case (op_dec)
                  OP_READ, OP_WRITE: begin
                     be_next    = 4'hF;
                     state_next = REQ;
                  end
                  OP_SUM_N: begin
                     be_next    = 4'hF;
                     // A zero count still passes through WAIT_DATA, which then adds nothing.
                     state_next = (cnt_clamped == '0) ? WAIT_DATA : REQ;
                  end
                  OP_STATUS: begin
                     rsp_next   = {30'b0, timeout_flag_reg, err_flag_reg};
                     state_next = RESP;
                  end
                  default: begin
                     rsp_next   = '0;
                     state_next = RESP;
                  end
               endcase
            end
         end

         REQ: begin
            if (mem_err) begin
               err_flag_next = 1'b1;
               rsp_next      = RSP_BUS_ERR;
               state_next    = RESP;
            end else if (mem_ack) begin
               if (op_reg == OP_WRITE) begin
                  rsp_next   = '0;
                  state_next = RESP;
               end else begin
                  state_next = WAIT_DATA;
               end
            end else if (timed_out) begin
               timeout_flag_next = 1'b1;
               rsp_next          = RSP_TIMEOUT;
               state_next        = RESP;
            end
         end

         WAIT_DATA: begin
            if (op_reg == OP_READ) begin
               rsp_next   = mem_rdata;
               state_next = RESP;
            end else begin
               if (cnt_reg != '0) begin
                  acc_next  = acc_reg + mem_rdata;
                  cnt_next  = cnt_reg - 1'b1;
                  addr_next = addr_reg + 30'd1;
               end
               if (cnt_next != '0) begin
                  state_next = REQ;
               end else begin
                  rsp_next   = acc_next;
                  state_next = RESP;
               end
            end
         end

         RESP: begin
            if (rsp_ready) begin
               if (op_reg == OP_STATUS) begin
                  err_flag_next     = 1'b0;
                  timeout_flag_next = 1'b0;
               end
               state_next = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign cmd_ready       = (state_reg == IDLE);
   assign rsp_valid       = (state_reg == RESP);
   assign rsp_outputs_0   = rsp_reg;
   assign req_read        = (state_reg == REQ) && (op_reg != OP_WRITE);
   assign req_write       = (state_reg == REQ) && (op_reg == OP_WRITE);
   assign req_burst       = 1'b0;
   assign req_address     = addr_reg;
   assign req_wdata       = wdata_reg;
   assign req_byte_enable = be_reg;

endmodule

// File: tb/tb_cfu_mem_cmd_seq.sv
// Scoreboard bench for cfu_mem_cmd_seq: responses expected in command order, bus requests checked inline.
module tb_cfu_mem_cmd_seq;
   import cfu_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [9:0]  cmd_function_id = '0;
   logic [31:0] cmd_inputs_0 = '0;
   logic [31:0] cmd_inputs_1 = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_outputs_0;
   logic        req_read, req_write, req_burst;
   logic [29:0] req_address;
   logic [31:0] req_wdata;
   logic [3:0]  req_byte_enable;
   logic        mem_ack = 1'b0;
   logic        mem_err = 1'b0;
   logic [31:0] mem_rdata = '0;

   int total = 0;
   int bad = 0;
   int neg_cnt = 0;
   int req_cycles = 0;
   int acc_neg = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   always @(negedge clk) begin
      neg_cnt <= neg_cnt + 1;
      if (req_read | req_write) req_cycles <= req_cycles + 1;
   end

   cfu_mem_cmd_seq #(
      .MAX_COUNT(256),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_function_id(cmd_function_id),
      .cmd_inputs_0   (cmd_inputs_0),
      .cmd_inputs_1   (cmd_inputs_1),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_outputs_0  (rsp_outputs_0),
      .req_read       (req_read),
      .req_write      (req_write),
      .req_burst      (req_burst),
      .req_address    (req_address),
      .req_wdata      (req_wdata),
      .req_byte_enable(req_byte_enable),
      .mem_ack        (mem_ack),
      .mem_err        (mem_err),
      .mem_rdata      (mem_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [6:0] f7, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      cmd_function_id = {f7, f3};
      cmd_inputs_0    = a;
      cmd_inputs_1    = b;
      cmd_valid       = 1'b1;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) check_eq("cmd_ready_wait", 32'(cmd_ready), 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      acc_neg   = neg_cnt;
   endtask

   task automatic serve_req(input string tag, input bit is_wr, input logic [29:0] addr,
                            input logic [31:0] wd, input int delay, input logic [31:0] rd,
                            input bit ack, input bit err);
      int n = 0;
      tick();
      while (!(req_read | req_write) && n < 50) begin
         tick();
         n++;
      end
      if (!(req_read | req_write)) begin
         check_eq({tag, "_req_wait"}, 32'(req_read | req_write), 1);
         return;
      end
      check_eq({tag, "_rd"}, 32'(req_read), 32'(!is_wr));
      check_eq({tag, "_wr"}, 32'(req_write), 32'(is_wr));
      check_eq({tag, "_addr"}, 32'(req_address), 32'(addr));
      check_eq({tag, "_be"}, 32'(req_byte_enable), 32'h0000_000F);
      check_eq({tag, "_burst"}, 32'(req_burst), 0);
      if (is_wr) check_eq({tag, "_wdata"}, req_wdata, wd);
      for (int i = 0; i < delay; i++) begin
         tick();
         check_eq({tag, "_hold_req"}, 32'(req_read | req_write), 1);
         check_eq({tag, "_hold_addr"}, 32'(req_address), 32'(addr));
      end
      mem_ack = ack;
      mem_err = err;
      tick();
      mem_ack   = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = rd;
      check_eq({tag, "_drop"}, 32'(req_read | req_write), 0);
   endtask

   task automatic get_rsp(input string tag, input int hold, input int exp_lat);
      int n = 0;
      logic [31:0] exp;
      tick();
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      if (!rsp_valid) begin
         check_eq({tag, "_rsp_wait"}, 32'(rsp_valid), 1);
         return;
      end
      if (exp_lat >= 0) check_eq({tag, "_lat"}, 32'(neg_cnt - acc_neg), 32'(exp_lat));
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_entry"}, 32'(sb.size()), 1);
         return;
      end
      exp = sb.pop_front();
      check_eq({tag, "_data"}, rsp_outputs_0, exp);
      for (int i = 0; i < hold; i++) begin
         tick();
         check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 1);
         check_eq({tag, "_hold_data"}, rsp_outputs_0, exp);
      end
      $display("txn %s rsp=0x%08h exp=0x%08h", tag, rsp_outputs_0, exp);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      int r0;
      int n;
      reset = 1'b1;
      #1 reset = 1'b0;
      tick();
      check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
      check_eq("rst_rsp_data", rsp_outputs_0, 0);
      check_eq("rst_req", 32'({req_read, req_write, req_burst}), 0);
      check_eq("rst_addr", 32'(req_address), 0);
      check_eq("rst_wdata", req_wdata, 0);
      check_eq("rst_be", 32'(req_byte_enable), 0);
      tick();
      reset = 1'b1;
      tick();
      check_eq("idle_cmd_ready", 32'(cmd_ready), 1);

      // WRITE with two wait cycles
      send_cmd(7'd0, OP_WRITE, 32'h0000_0100, 32'hCAFE_F00D);
      sb.push_back(32'h0);
      serve_req("write", 1'b1, 30'h40, 32'hCAFE_F00D, 2, 32'h0, 1'b1, 1'b0);
      get_rsp("write", 0, -1);

      // READ, immediate ack, response backpressured 5 cycles
      send_cmd(7'd0, OP_READ, 32'h0000_0103, 32'h0);
      sb.push_back(32'h1234_5678);
      serve_req("read", 1'b0, 30'h40, 32'h0, 0, 32'h1234_5678, 1'b1, 1'b0);
      get_rsp("read", 5, 3);

      // SUM_N with 32-bit wrap
      send_cmd(7'd0, OP_SUM_N, 32'h0000_0200, 32'd3);
      sb.push_back(32'h0000_0006);
      serve_req("sum0", 1'b0, 30'h80, 32'h0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      serve_req("sum1", 1'b0, 30'h81, 32'h0, 1, 32'h0000_0002, 1'b1, 1'b0);
      serve_req("sum2", 1'b0, 30'h82, 32'h0, 0, 32'h0000_0005, 1'b1, 1'b0);
      get_rsp("sum3", 0, -1);

      // SUM_N count 0: no bus traffic, response two cycles after accept
      r0 = req_cycles;
      send_cmd(7'd0, OP_SUM_N, 32'h0000_0200, 32'hFFFF_0000);
      sb.push_back(32'h0);
      get_rsp("sum_zero", 0, 2);
      check_eq("sum_zero_noreq", 32'(req_cycles), 32'(r0));

      // Address wrap at the top of the word space
      send_cmd(7'd0, OP_SUM_N, 32'hFFFF_FFFC, 32'd2);
      sb.push_back(32'd30);
      serve_req("wrap0", 1'b0, 30'h3FFF_FFFF, 32'h0, 0, 32'd10, 1'b1, 1'b0);
      serve_req("wrap1", 1'b0, 30'h0, 32'h0, 0, 32'd20, 1'b1, 1'b0);
      get_rsp("wrap", 0, -1);

      // Count clamp: 0x0101 requested, MAX_COUNT words summed
      send_cmd(7'd0, OP_SUM_N, 32'h0, 32'hABCD_0101);
      sb.push_back(32'd256);
      for (int i = 0; i < 256; i++)
         serve_req("clamp", 1'b0, 30'(i), 32'h0, 0, 32'd1, 1'b1, 1'b0);
      get_rsp("clamp", 0, -1);

      // Bus error on second word abandons the rest
      send_cmd(7'd0, OP_SUM_N, 32'h0, 32'd4);
      sb.push_back(RSP_BUS_ERR);
      serve_req("err0", 1'b0, 30'h0, 32'h0, 0, 32'd7, 1'b1, 1'b0);
      serve_req("err1", 1'b0, 30'h1, 32'h0, 0, 32'd9, 1'b0, 1'b1);
      r0 = req_cycles;
      get_rsp("err_sum", 0, -1);
      check_eq("err_no_more_req", 32'(req_cycles), 32'(r0));
      send_cmd(7'd0, OP_STATUS, 32'h0, 32'h0);
      sb.push_back(32'h1);
      get_rsp("status1", 0, -1);
      send_cmd(7'd0, OP_STATUS, 32'h0, 32'h0);
      sb.push_back(32'h0);
      get_rsp("status2", 0, -1);

      // ack and err together: error wins
      send_cmd(7'd0, OP_READ, 32'h0000_0040, 32'h0);
      sb.push_back(RSP_BUS_ERR);
      serve_req("ackerr", 1'b0, 30'h10, 32'h0, 0, 32'h1111_1111, 1'b1, 1'b1);
      get_rsp("ackerr", 0, -1);
      send_cmd(7'd0, OP_STATUS, 32'h0, 32'h0);
      sb.push_back(32'h1);
      get_rsp("status3", 0, -1);

      // Undefined encodings respond 0 without bus traffic
      r0 = req_cycles;
      send_cmd(7'd1, OP_READ, 32'h0000_0100, 32'h0);
      sb.push_back(32'h0);
      get_rsp("undef_f7", 0, 1);
      send_cmd(7'd0, 3'd5, 32'h0000_0100, 32'h0);
      sb.push_back(32'h0);
      get_rsp("undef_f3", 0, 1);
      check_eq("undef_noreq", 32'(req_cycles), 32'(r0));

      // Stray ack while idle is ignored
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("stray_ack_ready", 32'(cmd_ready), 1);
      check_eq("stray_ack_rsp", 32'(rsp_valid), 0);

      // Asynchronous reset during WAIT_DATA
      send_cmd(7'd0, OP_READ, 32'h0000_0044, 32'h0);
      serve_req("rst_read", 1'b0, 30'h11, 32'h0, 0, 32'h55AA_55AA, 1'b1, 1'b0);
      #2 reset = 1'b0;
      #1;
      check_eq("async_rst_rsp_valid", 32'(rsp_valid), 0);
      check_eq("async_rst_rsp_data", rsp_outputs_0, 0);
      check_eq("async_rst_req", 32'({req_read, req_write}), 0);
      check_eq("async_rst_addr", 32'(req_address), 0);
      check_eq("async_rst_wdata", req_wdata, 0);
      check_eq("async_rst_be", 32'(req_byte_enable), 0);
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("post_rst_ready", 32'(cmd_ready), 1);
         check_eq("post_rst_no_rsp", 32'(rsp_valid), 0);
      end

`ifdef CFU_MEM_TIMEOUT_EN
      send_cmd(7'd0, OP_READ, 32'h0000_0080, 32'h0);
      sb.push_back(RSP_TIMEOUT);
      n = 0;
      tick();
      while (req_read && n < 50) begin
         n++;
         tick();
      end
      check_eq("tmo_req_cycles", 32'(n), 32'd8);
      get_rsp("timeout", 0, -1);
      send_cmd(7'd0, OP_STATUS, 32'h0, 32'h0);
      sb.push_back(32'h2);
      get_rsp("status_tmo", 0, -1);
`else
      n = 0;
`endif

      check_eq("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
